// File: rtl/writeback_pkg.sv
// Shared widths for the writeback stage and its register file.
// Register count follows from the register-number width.
package writeback_pkg;

  localparam int WORD = 32;
  localparam int W_RD = 4;
  localparam int NREG = 2 ** W_RD;

endpackage

// File: rtl/writeback_reg_file.sv
// Architectural register file: NREG x WORD, one synchronous write port,
// two combinational read ports, asynchronously cleared to zero.
module writeback_reg_file
  import writeback_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [W_RD-1:0] waddr,
  input  logic [WORD-1:0] wdata,
  input  logic [W_RD-1:0] raddr_a,
  input  logic [W_RD-1:0] raddr_b,
  output logic [WORD-1:0] rdata_a,
  output logic [WORD-1:0] rdata_b
);

  logic [WORD-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: registers execute results, commits them to the register
// file, counts retirements, and serves decode with bypassed reads and a scoreboard.
module writeback
  import writeback_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  output logic            stall_o,
  input  logic [W_RD-1:0] rd_num_i,
  input  logic            wb_i,
  input  logic [WORD-1:0] rd_data_i,
  input  logic [W_RD-1:0] ra_num_i,
  input  logic [W_RD-1:0] rb_num_i,
  output logic [WORD-1:0] ra_data_o,
  output logic [WORD-1:0] rb_data_o,
  input  logic            issue_i,
  input  logic [W_RD-1:0] issue_rd_i,
  output logic [NREG-1:0] busy_o,
  input  logic            hw_we_i,
  input  logic [W_RD-1:0] hw_num_i,
  input  logic [WORD-1:0] hw_data_i,
  output logic [WORD-1:0] retired_o
);

  logic            v_r;
  logic            wb_r;
  logic [W_RD-1:0] rd_num_r;
  logic [WORD-1:0] rd_data_r;

  logic            commit;
  logic            pipe_we;
  logic            rf_we;
  logic [W_RD-1:0] rf_waddr;
  logic [WORD-1:0] rf_wdata;
  logic [WORD-1:0] rf_ra;
  logic [WORD-1:0] rf_rb;
  logic [NREG-1:0] busy_next;

  // A host write owns the single write port, so a pending commit waits a cycle.
  assign stall_o  = v_r & hw_we_i;
  assign commit   = v_r & ~hw_we_i;
  assign pipe_we  = commit & wb_r;
  assign rf_we    = hw_we_i | pipe_we;
  assign rf_waddr = hw_we_i ? hw_num_i  : rd_num_r;
  assign rf_wdata = hw_we_i ? hw_data_i : rd_data_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_r       <= 1'b0;
      wb_r      <= 1'b0;
      rd_num_r  <= '0;
      rd_data_r <= '0;
    end else if (!stall_o) begin
      v_r       <= v_i;
      wb_r      <= wb_i;
      rd_num_r  <= rd_num_i;
      rd_data_r <= rd_data_i;
    end
  end

  // Issue is applied after the clear so a same-cycle set of that register wins.
  always_comb begin
    busy_next = busy_o;
    if (pipe_we) begin
      busy_next[rd_num_r] = 1'b0;
    end
    if (issue_i) begin
      busy_next[issue_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_o    <= '0;
      retired_o <= '0;
    end else begin
      busy_o <= busy_next;
      if (commit) begin
        retired_o <= retired_o + WORD'(1);
      end
    end
  end

  writeback_reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (ra_num_i),
    .raddr_b (rb_num_i),
    .rdata_a (rf_ra),
    .rdata_b (rf_rb)
  );

  // Host data is newest, then the committing result, then the array.
  assign ra_data_o = (hw_we_i && hw_num_i == ra_num_i) ? hw_data_i :
                     (pipe_we && rd_num_r == ra_num_i) ? rd_data_r : rf_ra;
  assign rb_data_o = (hw_we_i && hw_num_i == rb_num_i) ? hw_data_i :
                     (pipe_we && rd_num_r == rb_num_i) ? rd_data_r : rf_rb;

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for writeback: bypass, scoreboard, host pre-emption,
// streaming, no-write retirement and asynchronous reset.
module tb_writeback;
  import writeback_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            v_i = 1'b0;
  logic            stall_o;
  logic [W_RD-1:0] rd_num_i = '0;
  logic            wb_i = 1'b0;
  logic [WORD-1:0] rd_data_i = '0;
  logic [W_RD-1:0] ra_num_i = '0;
  logic [W_RD-1:0] rb_num_i = '0;
  logic [WORD-1:0] ra_data_o;
  logic [WORD-1:0] rb_data_o;
  logic            issue_i = 1'b0;
  logic [W_RD-1:0] issue_rd_i = '0;
  logic [NREG-1:0] busy_o;
  logic            hw_we_i = 1'b0;
  logic [W_RD-1:0] hw_num_i = '0;
  logic [WORD-1:0] hw_data_i = '0;
  logic [WORD-1:0] retired_o;

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;
  logic [WORD-1:0] exp_regs [NREG];

  writeback dut (
    .clk        (clk),
    .rst        (rst),
    .v_i        (v_i),
    .stall_o    (stall_o),
    .rd_num_i   (rd_num_i),
    .wb_i       (wb_i),
    .rd_data_i  (rd_data_i),
    .ra_num_i   (ra_num_i),
    .rb_num_i   (rb_num_i),
    .ra_data_o  (ra_data_o),
    .rb_data_o  (rb_data_o),
    .issue_i    (issue_i),
    .issue_rd_i (issue_rd_i),
    .busy_o     (busy_o),
    .hw_we_i    (hw_we_i),
    .hw_num_i   (hw_num_i),
    .hw_data_i  (hw_data_i),
    .retired_o  (retired_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_result(input logic [W_RD-1:0] rd, input logic wb, input logic [WORD-1:0] data);
    v_i = 1'b1; rd_num_i = rd; wb_i = wb; rd_data_i = data;
  endtask

  task automatic test_reset();
    ra_num_i = 4'd3; rb_num_i = 4'd15;
    #3;
    checks++; if (busy_o !== 16'h0) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy_o, 16'h0); end
    checks++; if (retired_o !== 32'h0) begin errors++; $display("FAIL reset_retired: got %h expected %h", retired_o, 32'h0); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected %b", stall_o, 1'b0); end
    checks++; if (ra_data_o !== 32'h0) begin errors++; $display("FAIL reset_ra: got %h expected %h", ra_data_o, 32'h0); end
    checks++; if (rb_data_o !== 32'h0) begin errors++; $display("FAIL reset_rb: got %h expected %h", rb_data_o, 32'h0); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_bypass();
    drive_result(4'd3, 1'b1, 32'h1234);
    ra_num_i = 4'd3;
    tick();
    v_i = 1'b0;
    #2;
    checks++; if (ra_data_o !== 32'h1234) begin errors++; $display("FAIL bypass_ra: got %h expected %h", ra_data_o, 32'h1234); end
    checks++; if (retired_o !== 32'h0) begin errors++; $display("FAIL bypass_retired_pre: got %0d expected %0d", retired_o, 0); end
    tick();
    #2;
    exp_regs[3] = 32'h1234; exp_retired = 1;
    checks++; if (ra_data_o !== 32'h1234) begin errors++; $display("FAIL array_ra: got %h expected %h", ra_data_o, 32'h1234); end
    checks++; if (retired_o !== 32'd1) begin errors++; $display("FAIL bypass_retired: got %0d expected %0d", retired_o, 1); end
  endtask

  task automatic test_scoreboard();
    issue_i = 1'b1; issue_rd_i = 4'd5; ra_num_i = 4'd5;
    tick();
    issue_i = 1'b0;
    #2;
    checks++; if (busy_o !== 16'h0020) begin errors++; $display("FAIL busy_set: got %h expected %h", busy_o, 16'h0020); end
    tick();
    drive_result(4'd5, 1'b1, 32'h5555);
    tick();
    v_i = 1'b0;
    #2;
    checks++; if (busy_o !== 16'h0020) begin errors++; $display("FAIL busy_hold: got %h expected %h", busy_o, 16'h0020); end
    tick();
    #2;
    exp_retired++;
    checks++; if (busy_o !== 16'h0000) begin errors++; $display("FAIL busy_clear: got %h expected %h", busy_o, 16'h0000); end
    checks++; if (ra_data_o !== 32'h5555) begin errors++; $display("FAIL sb_ra5: got %h expected %h", ra_data_o, 32'h5555); end
    checks++; if (retired_o !== WORD'(exp_retired)) begin errors++; $display("FAIL sb_retired: got %0d expected %0d", retired_o, exp_retired); end
    // same-cycle issue and commit of r5: set wins
    drive_result(4'd5, 1'b1, 32'h6666);
    tick();
    v_i = 1'b0; issue_i = 1'b1; issue_rd_i = 4'd5;
    tick();
    issue_i = 1'b0;
    #2;
    exp_retired++;
    checks++; if (busy_o !== 16'h0020) begin errors++; $display("FAIL busy_set_wins: got %h expected %h", busy_o, 16'h0020); end
    checks++; if (ra_data_o !== 32'h6666) begin errors++; $display("FAIL sb_ra6: got %h expected %h", ra_data_o, 32'h6666); end
    drive_result(4'd5, 1'b1, 32'h7777);
    tick();
    v_i = 1'b0;
    tick();
    #2;
    exp_retired++; exp_regs[5] = 32'h7777;
    checks++; if (busy_o !== 16'h0000) begin errors++; $display("FAIL busy_clear2: got %h expected %h", busy_o, 16'h0000); end
    checks++; if (retired_o !== WORD'(exp_retired)) begin errors++; $display("FAIL sb_retired2: got %0d expected %0d", retired_o, exp_retired); end
  endtask

  task automatic test_host_stall();
    drive_result(4'd2, 1'b1, 32'hAA);
    ra_num_i = 4'd7; rb_num_i = 4'd2;
    tick();
    v_i = 1'b0; hw_we_i = 1'b1; hw_num_i = 4'd7; hw_data_i = 32'h55;
    #2;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL stall_c1: got %b expected %b", stall_o, 1'b1); end
    checks++; if (ra_data_o !== 32'h55) begin errors++; $display("FAIL host_bypass: got %h expected %h", ra_data_o, 32'h55); end
    checks++; if (rb_data_o !== 32'h0) begin errors++; $display("FAIL no_commit_bypass: got %h expected %h", rb_data_o, 32'h0); end
    tick();
    #2;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL stall_c2: got %b expected %b", stall_o, 1'b1); end
    checks++; if (retired_o !== WORD'(exp_retired)) begin errors++; $display("FAIL stall_retired_hold: got %0d expected %0d", retired_o, exp_retired); end
    tick();
    hw_we_i = 1'b0;
    #2;
    exp_regs[7] = 32'h55;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected %b", stall_o, 1'b0); end
    checks++; if (ra_data_o !== 32'h55) begin errors++; $display("FAIL host_array: got %h expected %h", ra_data_o, 32'h55); end
    checks++; if (rb_data_o !== 32'hAA) begin errors++; $display("FAIL deferred_bypass: got %h expected %h", rb_data_o, 32'hAA); end
    tick();
    #2;
    exp_retired++; exp_regs[2] = 32'hAA;
    checks++; if (rb_data_o !== 32'hAA) begin errors++; $display("FAIL deferred_array: got %h expected %h", rb_data_o, 32'hAA); end
    checks++; if (retired_o !== WORD'(exp_retired)) begin errors++; $display("FAIL stall_retired: got %0d expected %0d", retired_o, exp_retired); end
  endtask

  task automatic test_host_same_rd();
    drive_result(4'd4, 1'b1, 32'h2);
    ra_num_i = 4'd4;
    tick();
    v_i = 1'b0; hw_we_i = 1'b1; hw_num_i = 4'd4; hw_data_i = 32'h1;
    #2;
    checks++; if (ra_data_o !== 32'h1) begin errors++; $display("FAIL same_rd_host: got %h expected %h", ra_data_o, 32'h1); end
    tick();
    hw_we_i = 1'b0;
    #2;
    checks++; if (ra_data_o !== 32'h2) begin errors++; $display("FAIL same_rd_bypass: got %h expected %h", ra_data_o, 32'h2); end
    tick();
    #2;
    exp_retired++; exp_regs[4] = 32'h2;
    checks++; if (ra_data_o !== 32'h2) begin errors++; $display("FAIL same_rd_final: got %h expected %h", ra_data_o, 32'h2); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      drive_result(W_RD'(8 + k), 1'b1, 32'hB000 + k);
      tick();
      #2;
      checks++; if (retired_o !== WORD'(exp_retired + k)) begin errors++; $display("FAIL b2b_retired_%0d: got %0d expected %0d", k, retired_o, exp_retired + k); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall_%0d: got %b expected %b", k, stall_o, 1'b0); end
    end
    v_i = 1'b0;
    tick();
    #2;
    exp_retired += 4;
    checks++; if (retired_o !== WORD'(exp_retired)) begin errors++; $display("FAIL b2b_retired: got %0d expected %0d", retired_o, exp_retired); end
    for (int k = 0; k < 4; k++) begin
      exp_regs[8 + k] = 32'hB000 + k;
      ra_num_i = W_RD'(8 + k);
      #1;
      checks++; if (ra_data_o !== exp_regs[8 + k]) begin errors++; $display("FAIL b2b_reg%0d: got %h expected %h", 8 + k, ra_data_o, exp_regs[8 + k]); end
    end
  endtask

  task automatic test_no_write();
    for (int i = 0; i < 8; i++) begin
      drive_result(W_RD'(i), 1'b0, 32'hDEAD0000 | i);
      tick();
      if (i % 2 == 1) begin
        v_i = 1'b0;
        tick();
      end
    end
    v_i = 1'b0;
    tick();
    tick();
    #2;
    exp_retired += 8;
    checks++; if (retired_o !== WORD'(exp_retired)) begin errors++; $display("FAIL nowrite_retired: got %0d expected %0d", retired_o, exp_retired); end
    checks++; if (busy_o !== 16'h0) begin errors++; $display("FAIL nowrite_busy: got %h expected %h", busy_o, 16'h0); end
    for (int n = 0; n < NREG; n++) begin
      ra_num_i = W_RD'(n); rb_num_i = W_RD'(NREG - 1 - n);
      #1;
      checks++; if (ra_data_o !== exp_regs[n]) begin errors++; $display("FAIL nowrite_ra%0d: got %h expected %h", n, ra_data_o, exp_regs[n]); end
      checks++; if (rb_data_o !== exp_regs[NREG - 1 - n]) begin errors++; $display("FAIL nowrite_rb%0d: got %h expected %h", NREG - 1 - n, rb_data_o, exp_regs[NREG - 1 - n]); end
    end
  endtask

  task automatic test_reset_mid();
    drive_result(4'd9, 1'b1, 32'h999);
    issue_i = 1'b1; issue_rd_i = 4'd12;
    ra_num_i = 4'd9; rb_num_i = 4'd3;
    tick();
    v_i = 1'b0; issue_i = 1'b0;
    #2;
    checks++; if (busy_o !== 16'h1000) begin errors++; $display("FAIL mid_busy_pre: got %h expected %h", busy_o, 16'h1000); end
    rst = 1'b0;
    #1;
    checks++; if (busy_o !== 16'h0) begin errors++; $display("FAIL mid_busy: got %h expected %h", busy_o, 16'h0); end
    checks++; if (retired_o !== 32'h0) begin errors++; $display("FAIL mid_retired: got %0d expected %0d", retired_o, 0); end
    checks++; if (ra_data_o !== 32'h0) begin errors++; $display("FAIL mid_ra9: got %h expected %h", ra_data_o, 32'h0); end
    checks++; if (rb_data_o !== 32'h0) begin errors++; $display("FAIL mid_rb3: got %h expected %h", rb_data_o, 32'h0); end
    hw_we_i = 1'b1; hw_num_i = 4'd1; hw_data_i = 32'hF00D;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b expected %b", stall_o, 1'b0); end
    hw_we_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    #2;
    checks++; if (ra_data_o !== 32'h0) begin errors++; $display("FAIL mid_no_write: got %h expected %h", ra_data_o, 32'h0); end
    checks++; if (retired_o !== 32'h0) begin errors++; $display("FAIL mid_retired_after: got %0d expected %0d", retired_o, 0); end
  endtask

  initial begin
    for (int n = 0; n < NREG; n++) exp_regs[n] = '0;
    test_reset();
    test_bypass();
    test_scoreboard();
    test_host_stall();
    test_host_same_rd();
    test_back_to_back();
    test_no_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
